auth_pin_fsm: RTL

//  Card/PIN authorisation controller for the ATM datapath (successor to the single-bit T/P auth FSM).

---
 rtl/auth_pin_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/auth_pin_fsm.sv
// Card/PIN authorisation controller.
// Collects a PIN as a stream of digits and compares it with pin_ref. The card
// gets MAX_TRIES attempts and is retained (LOCK) once they are used up. PIN
// entry also has an inactivity timeout and a cancel path.
// The outputs are Moore outputs. They are registered from the next-state
// value, so they change on the same edge as state_dbg.
module auth_pin_fsm #(
    parameter int PIN_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int LOCK_CYC    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             card_in,
    input  logic                             cancel,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic [PIN_DIGITS*DIGIT_W-1:0]    pin_ref,
    output logic                             accept,
    output logic                             eject,
    output logic                             fail,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic [2:0]                       state_dbg
);

    localparam int BW  = PIN_DIGITS * DIGIT_W;
    localparam int CW  = $clog2(PIN_DIGITS + 1);
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW  = $clog2(LOCK_CYC + 1);
    localparam int TW  = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_PIN   = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_OK    = 3'd4;
    localparam logic [2:0] ST_EJECT = 3'd5;
    localparam logic [2:0] ST_FAIL  = 3'd6;
    localparam logic [2:0] ST_LOCK  = 3'd7;

    localparam logic [CW-1:0]  CNT_FULL  = CW'(PIN_DIGITS);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [TMW-1:0] TMR_LAST  = TMW'(TIMEOUT_CYC - 1);
    localparam logic [TMW-1:0] TMR_ONE   = TMW'(1);
    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_CYC - 1);
    localparam logic [LW-1:0]  LOCK_ONE  = LW'(1);
    localparam logic [TW-1:0]  TRY_MAX   = TW'(MAX_TRIES);
    localparam logic [TW-1:0]  TRY_ONE   = TW'(1);

    logic [2:0]     state_r, state_s;
    logic [BW-1:0]  buf_r, buf_s, shift_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [TMW-1:0] timer_r, timer_s;
    logic [LW-1:0]  lock_r, lock_s;
    logic [TW-1:0]  tries_r, tries_s;
    logic           accept_r, eject_r, fail_r, locked_r;

    // Next-state and datapath update for the authorisation sequence
    always_comb begin
        state_s = state_r;
        buf_s   = buf_r;
        cnt_s   = cnt_r;
        timer_s = timer_r;
        lock_s  = lock_r;
        tries_s = tries_r;
        shift_s = buf_r << DIGIT_W;
        shift_s[DIGIT_W-1:0] = digit;
        case (state_r)
            ST_IDLE: begin
                if (card_in) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                buf_s   = '0;
                cnt_s   = '0;
                timer_s = '0;
                tries_s = TRY_MAX;
                state_s = ST_PIN;
            end
            ST_PIN: begin
                if (cancel || !card_in) begin
                    state_s = ST_EJECT;
                end else if (enter) begin
                    // A digit strobe arriving together with enter is dropped
                    state_s = ST_CHECK;
                end else if (digit_valid) begin
                    timer_s = '0;
                    if (cnt_r < CNT_FULL) begin
                        buf_s = shift_s;
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                    if (timer_s == TMR_LAST) begin
                        state_s = ST_EJECT;
                    end else begin
                        state_s = ST_PIN;
                    end
                end
            end
            ST_CHECK: begin
                if ((cnt_r == CNT_FULL) && (buf_r == pin_ref)) begin
                    state_s = ST_OK;
                end else begin
                    if (tries_r != '0) begin
                        tries_s = tries_r - TRY_ONE;
                    end else begin
                        tries_s = '0;
                    end
                    if (tries_s == '0) begin
                        lock_s  = '0;
                        state_s = ST_LOCK;
                    end else begin
                        state_s = ST_FAIL;
                    end
                end
            end
            ST_FAIL: begin
                buf_s   = '0;
                cnt_s   = '0;
                timer_s = '0;
                state_s = ST_PIN;
            end
            ST_OK: begin
                if (enter || cancel || !card_in) begin
                    state_s = ST_EJECT;
                end else begin
                    state_s = ST_OK;
                end
            end
            ST_EJECT: begin
                if (!card_in) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EJECT;
                end
            end
            ST_LOCK: begin
                if (lock_r == LOCK_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    lock_s  = lock_r + LOCK_ONE;
                    state_s = ST_LOCK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered Moore outputs, with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            buf_r    <= '0;
            cnt_r    <= '0;
            timer_r  <= '0;
            lock_r   <= '0;
            tries_r  <= TRY_MAX;
            accept_r <= 1'b0;
            eject_r  <= 1'b0;
            fail_r   <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            buf_r    <= buf_s;
            cnt_r    <= cnt_s;
            timer_r  <= timer_s;
            lock_r   <= lock_s;
            tries_r  <= tries_s;
            accept_r <= (state_s == ST_OK);
            eject_r  <= (state_s == ST_EJECT);
            fail_r   <= (state_s == ST_FAIL) || (state_s == ST_LOCK);
            locked_r <= (state_s == ST_LOCK);
        end
    end

    assign accept     = accept_r;
    assign eject      = eject_r;
    assign fail       = fail_r;
    assign locked     = locked_r;
    assign tries_left = tries_r;
    assign state_dbg  = state_r;

endmodule
